// File: rtl/alu_share_if.sv
// Bundle of the two requester channels, the two response channels and the ALU
// operand/result wires around alu_share_ctrl.
interface alu_share_if #(
  parameter int W     = 32,
  parameter int FUN_W = 6
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. A request may be withdrawn before ready without effect; a
  // response is held with valid high and data stable until its ready is seen.
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;
  logic [FUN_W-1:0] req0_fun;
  logic             req0_sign;

  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;
  logic [FUN_W-1:0] req1_fun;
  logic             req1_sign;

  logic             rsp0_valid;
  logic [W-1:0]     rsp0_z;
  logic             rsp0_ready;

  logic             rsp1_valid;
  logic [W-1:0]     rsp1_z;
  logic             rsp1_ready;

  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [FUN_W-1:0] alu_fun;
  logic             alu_sign;
  logic [W-1:0]     alu_z;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_fun, req0_sign,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_fun, req1_sign,
    output req1_ready,
    output rsp0_valid, rsp0_z,
    input  rsp0_ready,
    output rsp1_valid, rsp1_z,
    input  rsp1_ready,
    output alu_a, alu_b, alu_fun, alu_sign,
    input  alu_z
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_fun, req0_sign,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_fun, req1_sign,
    input  req1_ready,
    input  rsp0_valid, rsp0_z,
    output rsp0_ready,
    input  rsp1_valid, rsp1_z,
    output rsp1_ready,
    input  alu_a, alu_b, alu_fun, alu_sign,
    output alu_z
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between the execute stage (req0) and the
// branch/compare unit (req1); one transaction in flight, IDLE -> EXEC -> RESP.
module alu_share_ctrl #(
  parameter int W     = 32,
  parameter int FUN_W = 6,
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  alu_share_if.slave  bus,
  output logic        busy,
  output logic [1:0]  state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q,      owner_d;
  logic [W-1:0]     alu_a_q,      alu_a_d;
  logic [W-1:0]     alu_b_q,      alu_b_d;
  logic [FUN_W-1:0] alu_fun_q,    alu_fun_d;
  logic             alu_sign_q,   alu_sign_d;
  logic [W-1:0]     result_q,     result_d;

  logic any_valid;
  logic winner;
  logic handshake;
  logic owner_ready;

  // The winner is always ready, so any valid request in IDLE is a handshake.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    winner    = 1'b0;
    if (RR_EN) begin
      if (bus.req0_valid && bus.req1_valid) begin
        winner = ~last_grant_q;
      end else begin
        winner = bus.req1_valid;
      end
    end else begin
      winner = ~bus.req0_valid;
    end
    handshake = (state_q == ST_IDLE) && any_valid && !reset;
  end

  assign bus.req0_ready = handshake && !winner;
  assign bus.req1_ready = handshake && winner;

  assign owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_fun_d    = alu_fun_q;
    alu_sign_d   = alu_sign_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          owner_d      = winner;
          last_grant_d = winner;
          alu_a_d      = winner ? bus.req1_a    : bus.req0_a;
          alu_b_d      = winner ? bus.req1_b    : bus.req0_b;
          alu_fun_d    = winner ? bus.req1_fun  : bus.req0_fun;
          alu_sign_d   = winner ? bus.req1_sign : bus.req0_sign;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Operands have been stable at the ALU for a full cycle here.
        result_d = bus.alu_z;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (owner_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_fun_q    <= '0;
      alu_sign_q   <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_fun_q    <= alu_fun_d;
      alu_sign_q   <= alu_sign_d;
      result_q     <= result_d;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_fun  = alu_fun_q;
  assign bus.alu_sign = alu_sign_q;

  // Response data reads as zero whenever its valid is low.
  assign bus.rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == ST_RESP) && owner_q;
  assign bus.rsp0_z     = bus.rsp0_valid ? result_q : '0;
  assign bus.rsp1_z     = bus.rsp1_valid ? result_q : '0;

  assign busy    = (state_q != ST_IDLE);
  assign state_o = state_q;

endmodule
